// File: rtl/mem_slot_arbiter.sv
// Slot-framed arbiter for one shared external-memory port: reserved leading slots for channel 0,
// optional locked bursts, and work-conserving round-robin for everything else.
module mem_slot_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SLOT_BITS = 3,
  parameter int unsigned RSV_SLOTS = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_CH-1:0]    i_req,
  input  logic [NUM_CH-1:0]    i_lock,
  output logic [NUM_CH-1:0]    o_gnt,
  output logic                 o_gnt_valid,
  output logic [2:0]           o_gnt_id,
  output logic [SLOT_BITS-1:0] o_slot,
  output logic                 o_slot_rsv
);

  localparam int unsigned IdW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BcW = 4;

  logic [SLOT_BITS-1:0] r_slot;
  logic                 r_gnt_vld;
  logic [IdW-1:0]       r_gnt_id;
  logic [BcW-1:0]       r_bcnt;
  logic [IdW-1:0]       r_rr;

  logic [SLOT_BITS-1:0] w_ns;
  logic                 w_ns_rsv;
  logic                 w_burst;
  logic [2*NUM_CH-1:0]  w_req_dbl;
  logic [NUM_CH-1:0]    w_req_rot;
  logic [IdW-1:0]       w_rr_off;
  logic                 w_rr_hit;
  logic [IdW:0]         w_rr_sum;
  logic [IdW-1:0]       w_rr_win;
  logic                 w_gnt_vld_d;
  logic [IdW-1:0]       w_gnt_id_d;
  logic [BcW-1:0]       w_bcnt_d;
  logic [IdW-1:0]       w_rr_d;

  assign w_ns     = r_slot + 1'b1;
  assign w_ns_rsv = (32'(w_ns) < RSV_SLOTS);

  // The previous owner is the burst owner; the lock is sampled fresh every decision.
  assign w_burst = r_gnt_vld && i_lock[r_gnt_id] && i_req[r_gnt_id] &&
                   (32'(r_bcnt) < MAX_BURST - 1);

  // Rotate requests so bit 0 is the channel at the rr pointer, then take the lowest set bit.
  assign w_req_dbl = {i_req, i_req} >> r_rr;
  assign w_req_rot = w_req_dbl[NUM_CH-1:0];

  always_comb begin
    w_rr_off = '0;
    w_rr_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_rr_off = IdW'(i);
        w_rr_hit = 1'b1;
      end
    end
  end

  assign w_rr_sum = {1'b0, r_rr} + {1'b0, w_rr_off};
  assign w_rr_win = (32'(w_rr_sum) >= NUM_CH) ? IdW'(32'(w_rr_sum) - NUM_CH)
                                               : w_rr_sum[IdW-1:0];

  always_comb begin
    w_gnt_vld_d = 1'b0;
    w_gnt_id_d  = '0;
    w_bcnt_d    = '0;
    w_rr_d      = r_rr;
    if (w_ns_rsv && i_req[0]) begin
      w_gnt_vld_d = 1'b1;
    end else if (w_burst) begin
      w_gnt_vld_d = 1'b1;
      w_gnt_id_d  = r_gnt_id;
      w_bcnt_d    = r_bcnt + 1'b1;
    end else if (w_rr_hit) begin
      w_gnt_vld_d = 1'b1;
      w_gnt_id_d  = w_rr_win;
      w_rr_d      = (32'(w_rr_win) == NUM_CH - 1) ? '0 : w_rr_win + IdW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot    <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_id  <= '0;
      r_bcnt    <= '0;
      r_rr      <= IdW'(1);
    end else begin
      r_slot    <= w_ns;
      r_gnt_vld <= w_gnt_vld_d;
      r_gnt_id  <= w_gnt_id_d;
      r_bcnt    <= w_bcnt_d;
      r_rr      <= w_rr_d;
    end
  end

  assign o_gnt       = r_gnt_vld ? (NUM_CH'(1) << r_gnt_id) : '0;
  assign o_gnt_valid = r_gnt_vld;
  assign o_gnt_id    = 3'(r_gnt_id);
  assign o_slot      = r_slot;
  assign o_slot_rsv  = (32'(r_slot) < RSV_SLOTS);

endmodule
